// File: rtl/spi_tx_feeder.sv
// Transmit feeder for an SPI byte sender: host FIFO, load/shift sequencing,
// programmable inter-byte gap and sticky overflow / sender-sync error flags.
module spi_tx_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned GAP   = 1
) (
  input  logic          clk_i,
  input  logic          clr_n_i,
  input  logic          enable_i,
  input  logic [7:0]    host_data_i,
  input  logic          host_wr_i,
  input  logic          clr_err_i,
  input  logic          snd_empty_i,
  output logic          host_full_o,
  output logic          host_empty_o,
  output logic [AW:0]   level_o,
  output logic [7:0]    snd_data_o,
  output logic          snd_write_o,
  output logic          snd_te_o,
  output logic          busy_o,
  output logic          overflow_o,
  output logic          sync_err_o
);

  localparam int unsigned LW       = AW + 1;
  localparam int unsigned GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [7:0]    snd_data_q;
  logic          snd_write_q, snd_te_q, busy_q;
  logic          host_full_q, host_empty_q;
  logic          overflow_q, sync_err_q;

  logic          full;
  logic          push, pop, can_start, shift_last, gap_last;

  // Next-state and FIFO bookkeeping; a pop happens exactly on entry to LOAD.
  always_comb begin
    full       = (level_q == LW'(DEPTH));
    push       = host_wr_i && !full;
    can_start  = enable_i && (level_q != '0);
    shift_last = (state_q == ST_SHIFT) && (bit_cnt_q == 3'd7);
    gap_last   = (state_q == ST_GAP) && (gap_cnt_q == GW'(GAP_LAST));
    state_d    = state_q;
    unique case (state_q)
      ST_IDLE:  if (can_start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (shift_last) begin
          if (GAP != 0)       state_d = ST_GAP;
          else if (can_start) state_d = ST_LOAD;
          else                state_d = ST_IDLE;
        end
      end
      ST_GAP:   if (gap_last) state_d = can_start ? ST_LOAD : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    pop     = (state_d == ST_LOAD);
    level_d = level_q + LW'(push) - LW'(pop);
  end

  // Storage array carries no reset; only pointers and LEVEL define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= host_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      snd_data_q   <= 8'h00;
      snd_write_q  <= 1'b0;
      snd_te_q     <= 1'b0;
      busy_q       <= 1'b0;
      host_full_q  <= 1'b0;
      host_empty_q <= 1'b1;
      overflow_q   <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        snd_data_q <= mem_q[rd_ptr_q];
      end
      bit_cnt_q    <= (state_q == ST_SHIFT) ? bit_cnt_q + 3'd1 : 3'd0;
      gap_cnt_q    <= ((state_q == ST_GAP) && !gap_last) ? gap_cnt_q + GW'(1) : '0;
      snd_write_q  <= (state_d == ST_LOAD);
      snd_te_q     <= (state_d == ST_SHIFT);
      busy_q       <= (state_d != ST_IDLE);
      host_full_q  <= (level_d == LW'(DEPTH));
      host_empty_q <= (level_d == '0);
      // Sticky flags: a new error in the same cycle as CLR_ERR wins.
      if (host_wr_i && full)            overflow_q <= 1'b1;
      else if (clr_err_i)               overflow_q <= 1'b0;
      if (shift_last && !snd_empty_i)   sync_err_q <= 1'b1;
      else if (clr_err_i)               sync_err_q <= 1'b0;
    end
  end

  assign host_full_o  = host_full_q;
  assign host_empty_o = host_empty_q;
  assign level_o      = level_q;
  assign snd_data_o   = snd_data_q;
  assign snd_write_o  = snd_write_q;
  assign snd_te_o     = snd_te_q;
  assign busy_o       = busy_q;
  assign overflow_o   = overflow_q;
  assign sync_err_o   = sync_err_q;

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Scoreboard bench for spi_tx_feeder: byte queue model, sticky-flag model,
// load spacing and shift-length checks against randomized and directed traffic.
module tb_spi_tx_feeder;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AW     = 3;
  localparam int unsigned GAP    = 1;
  localparam int          PERIOD = 9 + GAP;

  logic          clk = 1'b0;
  logic          clr_n, enable, host_wr, clr_err, snd_empty;
  logic [7:0]    host_data;
  logic          host_full, host_empty, snd_write, snd_te, busy, overflow, sync_err;
  logic [AW:0]   level;
  logic [7:0]    snd_data;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;

  logic          s_rst_n, s_wr, s_clr, s_empty;
  logic [7:0]    s_data;

  logic [7:0]    exp_q[$];
  int            load_cyc[$];
  int            m_level = 0;
  bit            m_ovf = 1'b0, m_sync = 1'b0, prev_write = 1'b0;
  int            te_run = 0;
  int            loads = 0;

  spi_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .GAP(GAP)) dut (
    .clk_i        (clk),
    .clr_n_i      (clr_n),
    .enable_i     (enable),
    .host_data_i  (host_data),
    .host_wr_i    (host_wr),
    .clr_err_i    (clr_err),
    .snd_empty_i  (snd_empty),
    .host_full_o  (host_full),
    .host_empty_o (host_empty),
    .level_o      (level),
    .snd_data_o   (snd_data),
    .snd_write_o  (snd_write),
    .snd_te_o     (snd_te),
    .busy_o       (busy),
    .overflow_o   (overflow),
    .sync_err_o   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs as seen by the DUT at each active edge.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    s_rst_n <= clr_n;
    s_wr    <= host_wr;
    s_data  <= host_data;
    s_clr   <= clr_err;
    s_empty <= snd_empty;
  end

  // Monitor: apply the edge just passed to the model, then compare outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!s_rst_n) begin
        exp_q.delete();
        m_level    = 0;
        m_ovf      = 1'b0;
        m_sync     = 1'b0;
        te_run     = 0;
        prev_write = 1'b0;
        chk("reset_te", 32'(snd_te), 0);
        chk("reset_write", 32'(snd_write), 0);
      end else begin
        if (s_clr) begin
          m_ovf  = 1'b0;
          m_sync = 1'b0;
        end
        if (s_wr) begin
          if (m_level < DEPTH) begin
            exp_q.push_back(s_data);
            m_level++;
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (te_run == 8 && !s_empty) m_sync = 1'b1;
        if (snd_write) begin
          loads++;
          load_cyc.push_back(cyc);
          chk("load_has_byte", 32'(exp_q.size() != 0), 1);
          chk("write_te_overlap", 32'(snd_te), 0);
          chk("write_one_cycle", 32'(prev_write), 0);
          if (exp_q.size() != 0) begin
            chk("snd_data", 32'(snd_data), 32'(exp_q.pop_front()));
            m_level--;
          end
        end
        if (snd_te) begin
          te_run++;
        end else if (te_run != 0) begin
          chk("te_length", 32'(te_run), 8);
          te_run = 0;
        end
        if (snd_write || snd_te) chk("busy_active", 32'(busy), 1);
        prev_write = snd_write;
      end
      chk("level", 32'(level), 32'(m_level));
      chk("host_full", 32'(host_full), 32'(m_level == DEPTH));
      chk("host_empty", 32'(host_empty), 32'(m_level == 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("sync_err", 32'(sync_err), 32'(m_sync));
    end
  end

  task automatic push_one(input logic [7:0] b, output int pc);
    host_data = b;
    host_wr   = 1'b1;
    @(posedge clk);
    #1;
    host_wr   = 1'b0;
    pc        = cyc;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    repeat (2) @(posedge clk);
    #1;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size() == 0 && !busy), 1);
  endtask

  task automatic wait_te_run(input int target, input string tag);
    int n = 0;
    @(negedge clk);
    #1;
    while (te_run != target && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_te_reached"}, 32'(te_run), 32'(target));
  endtask

  initial begin
    int pc, n0, l0, sent, guard, n;
    clr_n     = 1'b0;
    enable    = 1'b1;
    host_wr   = 1'b0;
    host_data = 8'h00;
    clr_err   = 1'b0;
    snd_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_snd_data", 32'(snd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_empty", 32'(host_empty), 1);
    chk("rst_level", 32'(level), 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    // Single byte: load one cycle after the push edge, then 8 shift cycles.
    n0 = loads;
    l0 = load_cyc.size();
    push_one(8'hA5, pc);
    wait_idle(60, "t1");
    chk("t1_loads", 32'(loads - n0), 1);
    if (load_cyc.size() > l0) chk("t1_latency", 32'(load_cyc[l0] - pc), 1);
    chk("t1_level", 32'(level), 0);

    // Three back-to-back pushes: loads spaced by one byte period.
    l0 = load_cyc.size();
    for (int i = 1; i <= 3; i++) begin
      host_data = 8'(i);
      host_wr   = 1'b1;
      @(posedge clk);
      #1;
    end
    host_wr = 1'b0;
    wait_idle(100, "t2");
    chk("t2_loads", 32'(load_cyc.size() - l0), 3);
    if (load_cyc.size() >= l0 + 3) begin
      chk("t2_space_a", 32'(load_cyc[l0 + 1] - load_cyc[l0]), 32'(PERIOD));
      chk("t2_space_b", 32'(load_cyc[l0 + 2] - load_cyc[l0 + 1]), 32'(PERIOD));
    end
    chk("t2_no_ovf", 32'(overflow), 0);

    // Fill while disabled: ninth byte dropped, overflow sticky until CLR_ERR.
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      host_data = 8'($urandom);
      host_wr   = 1'b1;
      @(posedge clk);
      #1;
    end
    host_wr = 1'b0;
    @(negedge clk);
    chk("t3_level", 32'(level), 8);
    chk("t3_full", 32'(host_full), 1);
    chk("t3_ovf", 32'(overflow), 1);
    @(posedge clk);
    #1;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    @(negedge clk);
    chk("t3_ovf_clr", 32'(overflow), 0);
    @(posedge clk);
    #1;
    enable = 1'b1;
    wait_idle(200, "t3");

    // Sender not empty at end of shift: sync error, next byte still loads.
    snd_empty = 1'b0;
    n0 = loads;
    push_one(8'h3C, pc);
    push_one(8'h4D, pc);
    n = 0;
    while (loads < n0 + 2 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t4_second_load", 32'(loads - n0), 2);
    snd_empty = 1'b1;
    chk("t4_sync", 32'(sync_err), 1);
    wait_idle(60, "t4");
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
    @(negedge clk);
    chk("t4_sync_clr", 32'(sync_err), 0);
    @(posedge clk);
    #1;

    // Reset in the 4th shift cycle with bytes still queued.
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push_one(8'($urandom), pc);
    enable = 1'b1;
    wait_te_run(4, "t5");
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    clr_n = 1'b1;
    @(negedge clk);
    chk("t5_te", 32'(snd_te), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_level", 32'(level), 0);
    chk("t5_empty", 32'(host_empty), 1);
    @(posedge clk);
    #1;

    // Random stream of 20 bytes, then an ENABLE drop mid-byte.
    n0 = loads;
    sent = 0;
    guard = 0;
    while (sent < 20 && guard < 3000) begin
      if (m_level < 6) begin
        push_one(8'($urandom), pc);
        sent++;
        repeat ($urandom_range(0, 7)) @(posedge clk);
        #1;
      end else begin
        @(posedge clk);
        #1;
      end
      guard++;
    end
    chk("t6_sent", 32'(sent), 20);
    wait_te_run(3, "t6");
    enable = 1'b0;
    chk("t6_backlog", 32'(exp_q.size() != 0), 1);
    n = loads;
    repeat (3 * PERIOD) @(posedge clk);
    #1;
    chk("t6_no_new_load", 32'(loads), 32'(n));
    chk("t6_idle", 32'(busy), 0);
    enable = 1'b1;
    wait_idle(400, "t6");
    chk("t6_total", 32'(loads - n0), 20);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
